// File: rtl/axil_cfg_pkg.sv
// axil_cfg_pkg: shared types and encodings for the AXI4-Lite to cfg-port bridge
package axil_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_e;

    typedef enum logic {
        PRIO_WRITE = 1'b0,
        PRIO_READ  = 1'b1
    } prio_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_cfg_bridge.sv
// axil_cfg_bridge: serialises AXI4-Lite accesses onto a one-cycle-latency BRAM-style cfg port
module axil_cfg_bridge
    import axil_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic                    bram_cfg_en,
    output logic [DATA_WIDTH/4-1:0] bram_cfg_we,
    output logic [ADDR_WIDTH-1:0]   bram_cfg_addr,
    output logic [DATA_WIDTH-1:0]   bram_cfg_data,
    input  logic [DATA_WIDTH-1:0]   bram_cfg_rdbk
);

    state_e                  state_q;
    prio_e                   prio_q;
    logic                    aw_held_q, w_held_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    bvalid_q, rvalid_q, en_q;
    logic [1:0]              bresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q, data_q;
    logic [DATA_WIDTH/4-1:0] we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;

    logic                    idle, contention, ar_win, wr_win;
    logic                    aw_take, w_take, ar_take, wr_go;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_strb;

    assign s_bvalid      = bvalid_q;
    assign s_bresp       = bresp_q;
    assign s_rvalid      = rvalid_q;
    assign s_rdata       = rdata_q;
    assign s_rresp       = RESP_OKAY;
    assign bram_cfg_en   = en_q;
    assign bram_cfg_we   = we_q;
    assign bram_cfg_addr = addr_q;
    assign bram_cfg_data = data_q;

    // Ready generation and arbitration; rstn gating keeps every ready low while in reset
    always_comb begin
        idle       = (state_q == IDLE) && rstn;
        contention = idle && !aw_held_q && !w_held_q && s_arvalid && (s_awvalid || s_wvalid);
        ar_win     = contention && (prio_q == PRIO_READ);
        wr_win     = contention && (prio_q == PRIO_WRITE);
        s_awready  = idle && !aw_held_q && !ar_win;
        s_wready   = idle && !w_held_q && !ar_win;
        s_arready  = idle && !aw_held_q && !w_held_q && !wr_win;
        aw_take    = s_awvalid && s_awready;
        w_take     = s_wvalid && s_wready;
        ar_take    = s_arvalid && s_arready;
        wr_go      = (aw_held_q || aw_take) && (w_held_q || w_take);
        wr_addr    = aw_held_q ? awaddr_q : s_awaddr;
        wr_data    = w_held_q ? wdata_q : s_wdata;
        wr_strb    = w_held_q ? wstrb_q : s_wstrb;
    end

    // Access FSM with registered AXI responses and cfg strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            prio_q    <= PRIO_WRITE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            we_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            en_q <= 1'b0;
            we_q <= '0;
            case (state_q)
                IDLE: begin
                    if (wr_go) begin
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        if (&wr_strb) begin
                            state_q <= WR_ISSUE;
                            en_q    <= 1'b1;
                            we_q    <= '1;
                            addr_q  <= wr_addr;
                            data_q  <= wr_data;
                        end else begin
                            state_q  <= WR_RESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= RESP_SLVERR;
                        end
                    end else begin
                        if (aw_take) begin
                            aw_held_q <= 1'b1;
                            awaddr_q  <= s_awaddr;
                        end
                        if (w_take) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= s_wdata;
                            wstrb_q  <= s_wstrb;
                        end
                        if (ar_take) begin
                            state_q <= RD_ISSUE;
                            en_q    <= 1'b1;
                            addr_q  <= s_araddr;
                        end
                    end
                end
                WR_ISSUE: begin
                    state_q  <= WR_RESP;
                    bvalid_q <= 1'b1;
                    bresp_q  <= RESP_OKAY;
                end
                WR_RESP: begin
                    if (s_bready) begin
                        state_q  <= IDLE;
                        bvalid_q <= 1'b0;
                        prio_q   <= PRIO_READ;
                    end
                end
                RD_ISSUE: state_q <= RD_WAIT;
                RD_WAIT: begin
                    state_q  <= RD_RESP;
                    rdata_q  <= bram_cfg_rdbk;
                    rvalid_q <= 1'b1;
                end
                RD_RESP: begin
                    if (s_rready) begin
                        state_q  <= IDLE;
                        rvalid_q <= 1'b0;
                        prio_q   <= PRIO_WRITE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cfg_bridge.sv
// tb_axil_cfg_bridge: directed checks of the AXI4-Lite to cfg-port bridge
module tb_axil_cfg_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, bram_cfg_addr, bram_cfg_data;
    logic [31:0] bram_cfg_rdbk = 32'h0;
    logic [3:0]  s_wstrb;
    logic [7:0]  bram_cfg_we;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, bram_cfg_en;

    int          checks = 0;
    int          errors = 0;
    int          en_cnt = 0;
    int          viol = 0;
    int          n0;
    logic        prev_en = 1'b0;
    logic        exp_w;
    logic [31:0] rd_val = 32'h0;
    logic [31:0] exp_rd_addr = 32'h0;

    axil_cfg_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .bram_cfg_en(bram_cfg_en), .bram_cfg_we(bram_cfg_we), .bram_cfg_addr(bram_cfg_addr),
        .bram_cfg_data(bram_cfg_data), .bram_cfg_rdbk(bram_cfg_rdbk)
    );

    always #5 clk = ~clk;

    // Register-file stand-in: read data appears only in the cycle after a matching read strobe
    always @(posedge clk)
        bram_cfg_rdbk <= (bram_cfg_en && bram_cfg_we == 8'h00 && bram_cfg_addr == exp_rd_addr) ? rd_val : 32'h0;

    // Strobe counter and back-to-back strobe detector
    always @(posedge clk) begin
        if (bram_cfg_en) en_cnt <= en_cnt + 1;
        if (bram_cfg_en && prev_en) viol <= viol + 1;
        prev_en <= bram_cfg_en;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
        s_araddr = '0; s_arvalid = 0; s_rready = 0;
        repeat (3) @(posedge clk);
        #1;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        #1;
        chk("rst_awready", s_awready, 0);
        chk("rst_wready", s_wready, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_en", bram_cfg_en, 0);
        chk("rst_we", bram_cfg_we, 0);
        chk("rst_addr", bram_cfg_addr, 0);
        chk("rst_rdata", s_rdata, 0);
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        rstn = 1'b1;
        #1;
        chk("post_rst_awready", s_awready, 1);
        chk("post_rst_arready", s_arready, 1);

        // Full write, AW and W together
        tick();
        s_awaddr = 32'h0001_0004; s_awvalid = 1; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1; s_bready = 1;
        #1;
        chk("w1_awready", s_awready, 1);
        chk("w1_wready", s_wready, 1);
        tick();
        s_awvalid = 0; s_wvalid = 0;
        chk("w1_en", bram_cfg_en, 1);
        chk("w1_we", bram_cfg_we, 8'hFF);
        chk("w1_addr", bram_cfg_addr, 32'h0001_0004);
        chk("w1_data", bram_cfg_data, 32'hDEAD_BEEF);
        tick();
        chk("w1_en_off", bram_cfg_en, 0);
        chk("w1_bvalid", s_bvalid, 1);
        chk("w1_bresp", s_bresp, 2'b00);
        tick();
        chk("w1_bvalid_off", s_bvalid, 0);
        chk("w1_awready_c3", s_awready, 1);

        // W arrives two cycles before AW; a pending AR must not be accepted meanwhile
        n0 = en_cnt;
        tick();
        s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1;
        #1;
        chk("w2_wready", s_wready, 1);
        tick();
        s_wvalid = 0; s_araddr = 32'h0001_0004; s_arvalid = 1;
        #1;
        chk("w2_arready_held", s_arready, 0);
        chk("w2_en_early", bram_cfg_en, 0);
        tick();
        chk("w2_arready_held2", s_arready, 0);
        chk("w2_en_early2", bram_cfg_en, 0);
        s_arvalid = 0; s_awaddr = 32'h0001_0008; s_awvalid = 1;
        #1;
        chk("w2_awready", s_awready, 1);
        tick();
        s_awvalid = 0;
        chk("w2_en", bram_cfg_en, 1);
        chk("w2_we", bram_cfg_we, 8'hFF);
        chk("w2_addr", bram_cfg_addr, 32'h0001_0008);
        chk("w2_data", bram_cfg_data, 32'h1234_5678);
        tick();
        chk("w2_bvalid", s_bvalid, 1);
        tick();
        chk("w2_strobes", en_cnt - n0, 1);

        // Partial-strobe write is rejected without touching the cfg port
        n0 = en_cnt;
        tick();
        s_awaddr = 32'h0001_000C; s_awvalid = 1; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'h3; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        chk("s3_en", bram_cfg_en, 0);
        chk("s3_bvalid", s_bvalid, 1);
        chk("s3_bresp", s_bresp, 2'b10);
        tick();
        chk("s3_bvalid_off", s_bvalid, 0);
        tick();
        chk("s3_strobes", en_cnt - n0, 0);

        // Read with five cycles of rready backpressure
        rd_val = 32'hDEAD_BEEF; exp_rd_addr = 32'h0001_0004; s_rready = 0;
        tick();
        s_araddr = 32'h0001_0004; s_arvalid = 1;
        #1;
        chk("r_arready", s_arready, 1);
        tick();
        s_arvalid = 0;
        chk("r_en", bram_cfg_en, 1);
        chk("r_we", bram_cfg_we, 8'h00);
        chk("r_addr", bram_cfg_addr, 32'h0001_0004);
        tick();
        chk("r_rvalid_c2", s_rvalid, 0);
        tick();
        chk("r_rvalid", s_rvalid, 1);
        chk("r_rdata", s_rdata, 32'hDEAD_BEEF);
        chk("r_rresp", s_rresp, 2'b00);
        s_arvalid = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("r_hold_rvalid", s_rvalid, 1);
            chk("r_hold_rdata", s_rdata, 32'hDEAD_BEEF);
            chk("r_hold_arready", s_arready, 0);
        end
        s_arvalid = 0; s_rready = 1;
        tick();
        chk("r_rvalid_off", s_rvalid, 0);

        // Simultaneous requests alternate W, R, W, R
        for (int i = 0; i < 4; i++) begin
            exp_w = (i % 2 == 0);
            tick();
            s_awaddr = 32'h0001_0020 + 32'(i * 4); s_wdata = 32'h1111_0000 + 32'(i); s_wstrb = 4'hF;
            s_araddr = 32'h0001_0040 + 32'(i * 4); rd_val = 32'hA5A5_0000 + 32'(i); exp_rd_addr = s_araddr;
            s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
            #1;
            chk("c_awready", s_awready, exp_w);
            chk("c_arready", s_arready, !exp_w);
            tick();
            s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
            chk("c_en", bram_cfg_en, 1);
            chk("c_we", bram_cfg_we, exp_w ? 8'hFF : 8'h00);
            chk("c_addr", bram_cfg_addr, exp_w ? s_awaddr : s_araddr);
            if (exp_w) begin
                tick();
                chk("c_bvalid", s_bvalid, 1);
            end else begin
                tick();
                tick();
                chk("c_rvalid", s_rvalid, 1);
                chk("c_rdata", s_rdata, rd_val);
            end
        end

        // Reset while in RD_WAIT aborts the read
        tick();
        rd_val = 32'h55AA_55AA; exp_rd_addr = 32'h0001_0004;
        s_araddr = 32'h0001_0004; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        chk("a_en", bram_cfg_en, 1);
        tick();
        rstn = 1'b0;
        #1;
        chk("a_en_rst", bram_cfg_en, 0);
        chk("a_rvalid_rst", s_rvalid, 0);
        chk("a_rdata_rst", s_rdata, 0);
        chk("a_addr_rst", bram_cfg_addr, 0);
        chk("a_arready_rst", s_arready, 0);
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("a_rvalid_after", s_rvalid, 0);
            chk("a_en_after", bram_cfg_en, 0);
        end
        rd_val = 32'h0BAD_F00D; exp_rd_addr = 32'h0001_0010;
        tick();
        s_araddr = 32'h0001_0010; s_arvalid = 1;
        #1;
        chk("a2_arready", s_arready, 1);
        tick();
        s_arvalid = 0;
        tick();
        tick();
        chk("a2_rvalid", s_rvalid, 1);
        chk("a2_rdata", s_rdata, 32'h0BAD_F00D);
        tick();
        chk("en_back_to_back", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_cfg_bridge.md
# axil_cfg_bridge

AXI4-Lite slave that converts host register accesses into the single-cycle BRAM-style configuration port consumed by the system configuration register file. It sits directly upstream of that register file, in place of a vendor AXI BRAM controller, and serialises reads and writes so that only one access is outstanding at a time. It issues only full-word writes, matches the register file's one-cycle readback latency, and returns AXI responses.

## Interface
- ADDR_WIDTH, 32, AXI and cfg address width
- DATA_WIDTH, 32, data width; a multiple of 8
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- s_awaddr / s_awvalid / s_awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- s_wdata / s_wstrb / s_wvalid / s_wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
- s_bresp / s_bvalid / s_bready  out/out/in  2/1/1  write response channel
- s_araddr / s_arvalid / s_arready  in/in/out  ADDR_WIDTH/1/1  read address channel
- s_rdata / s_rresp / s_rvalid / s_rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel
- bram_cfg_en  out  1  access strobe, one cycle per access
- bram_cfg_we  out  DATA_WIDTH/4  write enable: all ones on a write, zero on a read
- bram_cfg_addr  out  ADDR_WIDTH  byte address, passed through unmodified
- bram_cfg_data  out  DATA_WIDTH  write data
- bram_cfg_rdbk  in  DATA_WIDTH  readback from the register file; valid one cycle after a read strobe

## Operation
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
- AW and W are accepted independently in IDLE.
  - Each is latched into its own holding register with a held flag.
  - s_awready = IDLE & !aw_held & !ar_win; s_wready = IDLE & !w_held & !ar_win.
- s_arready = IDLE & !aw_held & !w_held & !wr_win. A read is never accepted while half of a write is held.
- Arbitration happens only when IDLE, nothing is held, and s_arvalid is asserted together with (s_awvalid | s_wvalid).
  - The `prio` flag decides the winner. ar_win = contention & prio==READ; wr_win = contention & prio==WRITE.
  - `prio` resets to WRITE. It flips to READ after each completed write response and to WRITE after each completed read response.
- IDLE -> WR_ISSUE when both the AW and W halves are held (or arrive) and all wstrb bits are 1.
- IDLE -> WR_RESP directly when both halves are held but wstrb is partial. No cfg strobe is issued, and bresp = SLVERR (2'b10).
- WR_ISSUE: bram_cfg_en=1, bram_cfg_we=all ones, address and data taken from the holding registers. Clears both held flags. Goes to WR_RESP.
- WR_RESP: s_bvalid=1, held until s_bready. bresp = OKAY (2'b00) unless the write was rejected. Goes to IDLE.
- IDLE -> RD_ISSUE on an AR handshake; the address is latched.
- RD_ISSUE: bram_cfg_en=1, bram_cfg_we=0. Goes to RD_WAIT.
- RD_WAIT: s_rdata <= bram_cfg_rdbk. Goes to RD_RESP.
- RD_RESP: s_rvalid=1, rresp=OKAY, s_rdata held stable until s_rready. Goes to IDLE.
- Outside an issue state: bram_cfg_en=0 and bram_cfg_we=0. bram_cfg_addr and bram_cfg_data hold their last values.

## Timing
- Reset values: every output is 0, FSM in IDLE, held flags clear, prio=WRITE. All ready signals are low during reset and go high in the first IDLE cycle after reset.
- Write, with AW and W handshaking in cycle 0: cfg strobe in cycle 1, s_bvalid from cycle 2. With bready tied high, a new AW/W is accepted in cycle 3.
- Read, with AR handshaking in cycle 0: cfg strobe in cycle 1, rdbk sampled at the end of cycle 2, s_rvalid from cycle 3.
- All outputs come from registers, except the ready signals. The ready signals combine state with same-cycle valid, which AXI permits.
- Backpressure: bvalid/rvalid and their payloads stay stable until the handshake. No new request is accepted before the handshake.
- Reset mid-transaction aborts the transaction: no strobe and no response after reset is released.
- bram_cfg_en is never high on two consecutive cycles.

## Structure
- Package axil_cfg_pkg: state enum; RESP_OKAY=2'b00 and RESP_SLVERR=2'b10; the READ/WRITE priority encoding.
- Single module with no sub-module: holding registers, FSM and arbiter are small enough to stay flat.

## Test plan
- AW and W in the same cycle, addr 0x0001_0004, data 0xDEADBEEF, wstrb 0xF -> strobe in cycle 1 with we=0xFF and that addr/data; bresp OKAY in cycle 2.
- W two cycles before AW, addr 0x0001_0008 -> exactly one strobe, issued only after AW arrives; s_arready stays low while W alone is held.
- Read of 0x0001_0004 with rdbk driven to 0xDEADBEEF one cycle after the strobe -> s_rdata=0xDEADBEEF, rvalid in cycle 3; with s_rready held low for 5 cycles, rdata stays stable.
- Write with wstrb 0x3 -> no bram_cfg_en pulse at all; bresp=SLVERR.
- Simultaneous AR and AW/W, repeated 4 times -> grants alternate W, R, W, R; no starvation.
- rstn asserted in RD_WAIT -> all outputs 0 immediately; after release, no rvalid appears and the next read works normally.
